// File: rtl/dec_pkg.sv
// Shared types and helpers for the 4x16 decoder checkers.
package dec_pkg;

    localparam int CODE_W = 4;
    localparam int OUT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        CHECK,
        DONE
    } state_e;

    localparam logic [CODE_W-1:0] LAST_CODE = 4'hF;

    // One-hot golden output for a 4-bit code.
    function automatic logic [OUT_W-1:0] onehot16(input logic [CODE_W-1:0] code);
        return 16'h0001 << code;
    endfunction

endpackage

// File: rtl/dec_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and its environment.
interface dec_sweep_checker_if;
    import dec_pkg::*;

    logic              start;
    logic              X;
    logic              Y;
    logic              Z;
    logic              W;
    logic [OUT_W-1:0]  D;
    logic              busy;
    logic              done;
    logic              pass;
    logic [4:0]        err_count;
    logic [OUT_W-1:0]  stuck_hi_mask;
    logic [OUT_W-1:0]  stuck_lo_mask;
    logic [CODE_W-1:0] first_fail_code;
    logic              first_fail_valid;

    // Checker side.
    modport master (
        input  start, D,
        output X, Y, Z, W, busy, done, pass, err_count,
               stuck_hi_mask, stuck_lo_mask, first_fail_code, first_fail_valid
    );

    // Environment side: decoder under test plus controller.
    modport slave (
        output start, D,
        input  X, Y, Z, W, busy, done, pass, err_count,
               stuck_hi_mask, stuck_lo_mask, first_fail_code, first_fail_valid
    );

endinterface

// File: rtl/dec_4x16_golden.sv
// Combinational reference 4x16 decoder: code to one-hot expected output.
module dec_4x16_golden
    import dec_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  expected
);

    assign expected = onehot16(code);

endmodule

// File: rtl/dec_sweep_checker.sv
// Exhaustive sweep of a 4x16 decoder: drives all 16 codes, compares each
// settled response with the one-hot golden value and accumulates results.
module dec_sweep_checker
    import dec_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    dec_sweep_checker_if.master bus
);

    // Settle windows shorter than one cycle collapse to one cycle.
    localparam int          SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_EFF - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_DRIVE  = DRIVE;
    localparam logic [2:0] S_SAMPLE = SAMPLE;
    localparam logic [2:0] S_CHECK  = CHECK;
    localparam logic [2:0] S_DONE   = DONE;

    logic [2:0]        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [31:0]       settle_q, settle_d;
    logic [OUT_W-1:0]  d_s_q, d_s_d;
    logic [4:0]        err_q, err_d;
    logic [OUT_W-1:0]  hi_q, hi_d;
    logic [OUT_W-1:0]  lo_q, lo_d;
    logic [CODE_W-1:0] ffc_q, ffc_d;
    logic              ffv_q, ffv_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [OUT_W-1:0]  expected;

    dec_4x16_golden u_golden (
        .code     (code_q),
        .expected (expected)
    );

    // Next-state and result accumulation.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        settle_d = settle_q;
        d_s_d    = d_s_q;
        err_d    = err_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ffc_d    = ffc_q;
        ffv_d    = ffv_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    code_d   = '0;
                    settle_d = '0;
                    err_d    = '0;
                    hi_d     = '0;
                    lo_d     = '0;
                    ffc_d    = '0;
                    ffv_d    = 1'b0;
                    pass_d   = 1'b0;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            S_SAMPLE: begin
                d_s_d   = bus.D;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (d_s_q != expected) begin
                    err_d = err_q + 5'd1;
                    if (!ffv_q) begin
                        ffc_d = code_q;
                        ffv_d = 1'b1;
                    end
                end
                hi_d = hi_q | (d_s_q & ~expected);
                lo_d = lo_q | (expected & ~d_s_q);
                if (code_q == LAST_CODE) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    code_d   = code_q + 4'd1;
                    settle_d = '0;
                    state_d  = S_DRIVE;
                end
            end
            S_DONE: begin
                code_d  = LAST_CODE;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            settle_q <= '0;
            d_s_q    <= '0;
            err_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ffc_q    <= '0;
            ffv_q    <= 1'b0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            settle_q <= settle_d;
            d_s_q    <= d_s_d;
            err_q    <= err_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ffc_q    <= ffc_d;
            ffv_q    <= ffv_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.X                = code_q[3];
    assign bus.Y                = code_q[2];
    assign bus.Z                = code_q[1];
    assign bus.W                = code_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.stuck_hi_mask    = hi_q;
    assign bus.stuck_lo_mask    = lo_q;
    assign bus.first_fail_code  = ffc_q;
    assign bus.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_dec_sweep_checker.sv
// Bench for dec_sweep_checker: behavioural decoder with selectable faults,
// scoreboard of expected sweep results and code sequence.
module tb_dec_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   fault_mode = 0;

    always #5 clk = ~clk;

    dec_sweep_checker_if bus2 ();
    dec_sweep_checker_if bus4 ();

    dec_sweep_checker #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    dec_sweep_checker #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.master)
    );

    typedef struct packed {
        logic [4:0]  err;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [3:0]  ffc;
        logic        ffv;
        logic        pass;
    } res_t;

    res_t exp_q[$];
    int   code_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Decoder under test: 0 good, 1 D[5] stuck-0, 2 D[3] stuck-1, 3 X/Y swapped.
    function automatic logic [15:0] dec_model(input logic [3:0] c, input int mode);
        logic [3:0]  ci;
        logic [15:0] d;
        ci = (mode == 3) ? {c[2], c[3], c[1:0]} : c;
        d  = 16'h0001 << ci;
        if (mode == 1) d[5] = 1'b0;
        if (mode == 2) d[3] = 1'b1;
        return d;
    endfunction

    always_comb bus2.D = dec_model({bus2.X, bus2.Y, bus2.Z, bus2.W}, fault_mode);
    always_comb bus4.D = dec_model({bus4.X, bus4.Y, bus4.Z, bus4.W}, fault_mode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t g, input res_t e);
        check({tag, ".err"},  32'(g.err),  32'(e.err));
        check({tag, ".hi"},   32'(g.hi),   32'(e.hi));
        check({tag, ".lo"},   32'(g.lo),   32'(e.lo));
        check({tag, ".ffc"},  32'(g.ffc),  32'(e.ffc));
        check({tag, ".ffv"},  32'(g.ffv),  32'(e.ffv));
        check({tag, ".pass"}, 32'(g.pass), 32'(e.pass));
    endtask

    function automatic res_t model_sweep(input int mode);
        res_t        r;
        logic [15:0] d, e;
        r = '0;
        for (int c = 0; c < 16; c++) begin
            d = dec_model(4'(c), mode);
            e = 16'h0001 << c;
            if (d != e) begin
                r.err++;
                if (!r.ffv) begin
                    r.ffc = 4'(c);
                    r.ffv = 1'b1;
                end
            end
            r.hi |= d & ~e;
            r.lo |= e & ~d;
        end
        r.pass = (r.err == 5'd0);
        return r;
    endfunction

    task automatic sample(input int which, output res_t r, output logic busy,
                          output logic done, output logic [3:0] code);
        if (which == 2) begin
            r    = '{bus2.err_count, bus2.stuck_hi_mask, bus2.stuck_lo_mask,
                     bus2.first_fail_code, bus2.first_fail_valid, bus2.pass};
            busy = bus2.busy;
            done = bus2.done;
            code = {bus2.X, bus2.Y, bus2.Z, bus2.W};
        end else begin
            r    = '{bus4.err_count, bus4.stuck_hi_mask, bus4.stuck_lo_mask,
                     bus4.first_fail_code, bus4.first_fail_valid, bus4.pass};
            busy = bus4.busy;
            done = bus4.done;
            code = {bus4.X, bus4.Y, bus4.Z, bus4.W};
        end
    endtask

    task automatic drive_start(input int which, input logic v);
        if (which == 2) bus2.start = v;
        else            bus4.start = v;
    endtask

    task automatic check_idle(input string tag, input int which, input res_t e,
                              input logic [3:0] exp_code);
        res_t       r;
        logic       busy, done;
        logic [3:0] code;
        sample(which, r, busy, done, code);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".code"}, 32'(code), 32'(exp_code));
        check_res(tag, r, e);
    endtask

    // Edge n=1 is the edge that samples start; done must be seen after edge
    // 16*(settle+2)+1. dup_at re-pulses start once that code is seen,
    // rst_at pulls reset once that code is seen.
    task automatic run_sweep(input string tag, input int which, input int mode,
                             input int settle, input int dup_at, input int rst_at,
                             input int hold);
        res_t       r, e;
        logic       busy, done;
        logic [3:0] code;
        int         n, last, lat;
        bit         dup_pending, finished;
        lat        = 16 * (settle + 2) + 1;
        fault_mode = mode;
        e          = model_sweep(mode);
        exp_q.push_back(e);
        for (int c = 0; c < 16; c++) code_q.push_back(c);
        @(negedge clk);
        drive_start(which, 1'b1);
        @(posedge clk);
        #1;
        n           = 1;
        last        = -1;
        finished    = 1'b0;
        dup_pending = 1'b0;
        sample(which, r, busy, done, code);
        check({tag, ".busy_on"}, 32'(busy), 1);
        while (!finished && n <= lat + 20) begin
            if (busy && int'(code) != last) begin
                last = int'(code);
                if (code_q.size() == 0) check({tag, ".code_extra"}, 32'(code), 16);
                else check({tag, ".code_seq"}, 32'(code), 32'(code_q.pop_front()));
                if (int'(code) == dup_at) dup_pending = 1'b1;
            end
            if (busy && int'(code) == rst_at) begin
                @(negedge clk);
                drive_start(which, 1'b0);
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check_idle({tag, ".reset"}, which, '0, 4'h0);
                @(negedge clk);
                rst_n = 1'b1;
                code_q.delete();
                void'(exp_q.pop_front());
                finished = 1'b1;
            end else if (done) begin
                check({tag, ".latency"}, 32'(n), 32'(lat));
                check({tag, ".done_code"}, 32'(code), 32'hF);
                check({tag, ".codes_left"}, 32'(code_q.size()), 0);
                check_res(tag, r, exp_q.pop_front());
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk);
                    #1;
                    check_idle({tag, ".hold"}, which, e, 4'hF);
                end
                finished = 1'b1;
            end else begin
                @(negedge clk);
                drive_start(which, dup_pending);
                dup_pending = 1'b0;
                @(posedge clk);
                #1;
                n++;
                sample(which, r, busy, done, code);
            end
        end
        if (!finished) begin
            check({tag, ".timeout"}, 0, 1);
            code_q.delete();
            exp_q.delete();
        end
        @(negedge clk);
        drive_start(which, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus2.start = 1'b0;
        bus4.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset2", 2, '0, 4'h0);
        check_idle("reset4", 4, '0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep("good",      2, 0, 2, -1, -1, 1);
        run_sweep("d5_lo",     2, 1, 2, -1, -1, 1);
        run_sweep("d3_hi",     2, 2, 2, -1, -1, 1);
        run_sweep("xy_swap",   2, 3, 2, -1, -1, 1);
        run_sweep("dup_start", 2, 0, 2,  3, -1, 1);
        run_sweep("mid_reset", 2, 3, 2, -1,  7, 0);
        run_sweep("after_rst", 2, 0, 2, -1, -1, 1);
        run_sweep("settle4",   4, 0, 4, -1, -1, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
